// File: rtl/sptag_ctrl_pkg.sv
// Shared constants and types for the speculative-tag branch-resolution controller.
package sptag_ctrl_pkg;

    // One-hot speculative tag width; the order queue holds SPTAG_WIDTH_DEF-1 branches.
    localparam int SPTAG_WIDTH_DEF = 5;

    // Architectural PC width used for redirect targets.
    localparam int RV32_PC_WIDTH = 32;

    // Width needed to count in-flight branches for the default tag width.
    localparam int SPDEPTH_WIDTH = $clog2(SPTAG_WIDTH_DEF);

    // Retire pulse currently being presented on the outputs.
    typedef enum logic [1:0] {
        RET_IDLE = 2'd0,
        RET_SUC  = 2'd1,
        RET_MISS = 2'd2
    } ret_state_e;

endpackage

// File: rtl/sptag_order_q.sv
// Program-order branch queue: circular buffer with dual push, tag-match
// resolution write port, head pop and whole-queue flush.
module sptag_order_q
    import sptag_ctrl_pkg::*;
#(
    parameter int SPTAG_WIDTH = SPTAG_WIDTH_DEF,
    parameter int PC_WIDTH    = RV32_PC_WIDTH,
    parameter int CNT_W       = $clog2(SPTAG_WIDTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push1,
    input  logic [SPTAG_WIDTH-1:0] push1_tag,
    input  logic                   push2,
    input  logic [SPTAG_WIDTH-1:0] push2_tag,
    input  logic                   pop,
    input  logic                   flush,
    input  logic                   res_en,
    input  logic [SPTAG_WIDTH-1:0] res_tag,
    input  logic                   res_miss,
    input  logic [PC_WIDTH-1:0]    res_target,
    output logic [SPTAG_WIDTH-1:0] head_tag,
    output logic                   head_done,
    output logic                   head_miss,
    output logic [PC_WIDTH-1:0]    head_target,
    output logic [CNT_W-1:0]       count
);

    localparam int DEPTH = SPTAG_WIDTH - 1;
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [SPTAG_WIDTH-1:0] tag_q [DEPTH];
    logic [SPTAG_WIDTH-1:0] tag_d [DEPTH];
    logic [PC_WIDTH-1:0]    tgt_q [DEPTH];
    logic [PC_WIDTH-1:0]    tgt_d [DEPTH];
    logic [DEPTH-1:0]       done_q, done_d;
    logic [DEPTH-1:0]       miss_q, miss_d;
    logic [PTR_W-1:0]       head_q, head_d;
    logic [PTR_W-1:0]       tail_q, tail_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [DEPTH-1:0]       valid;
    logic [DEPTH-1:0]       hit;
    logic [PTR_W-1:0]       slot1, slot2;
    logic                   overflow;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    // Occupancy mask and resolution tag match against occupied entries only.
    always_comb begin
        int off;
        off   = 0;
        valid = '0;
        hit   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off      = (i >= int'(head_q)) ? (i - int'(head_q)) : (i + DEPTH - int'(head_q));
            valid[i] = (off < int'(cnt_q));
            hit[i]   = res_en && valid[i] && (tag_q[i] == res_tag);
        end
    end

    // Next-state for entries and pointers: resolve writes, then flush or pop/push.
    always_comb begin
        tag_d    = tag_q;
        tgt_d    = tgt_q;
        done_d   = done_q;
        miss_d   = miss_q;
        head_d   = head_q;
        tail_d   = tail_q;
        cnt_d    = cnt_q;
        slot1    = tail_q;
        slot2    = push1 ? ptr_inc(tail_q) : tail_q;
        overflow = 1'b0;

        for (int i = 0; i < DEPTH; i++) begin
            if (hit[i]) begin
                done_d[i] = 1'b1;
                miss_d[i] = res_miss;
                tgt_d[i]  = res_target;
            end
        end

        if (flush) begin
            // A mispredict discards every younger branch including this cycle's pushes.
            head_d = tail_q;
            cnt_d  = '0;
        end else begin
            if (pop) begin
                head_d = ptr_inc(head_q);
            end
            if (push1) begin
                tag_d[slot1]  = push1_tag;
                done_d[slot1] = 1'b0;
            end
            if (push2) begin
                tag_d[slot2]  = push2_tag;
                done_d[slot2] = 1'b0;
            end
            if (push1 && push2) begin
                tail_d = ptr_inc(ptr_inc(tail_q));
            end else if (push1 || push2) begin
                tail_d = ptr_inc(tail_q);
            end
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, push1} + {{(CNT_W-1){1'b0}}, push2}
                          - {{(CNT_W-1){1'b0}}, pop};
            overflow = (int'(cnt_q) + int'(push1) + int'(push2) - int'(pop)) > DEPTH;
        end
    end

    // Control state: pointers, count and done flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
            done_q <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    // Entry payload: only meaningful while the matching done/occupancy says so.
    always_ff @(posedge clk) begin
        tag_q  <= tag_d;
        tgt_q  <= tgt_d;
        miss_q <= miss_d;
    end

    // The generator's allocable check keeps dispatch from outrunning the queue.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst) !overflow);

    assign head_tag    = tag_q[head_q];
    assign head_done   = done_q[head_q] && (cnt_q != '0);
    assign head_miss   = miss_q[head_q];
    assign head_target = tgt_q[head_q];
    assign count       = cnt_q;

endmodule

// File: rtl/sptag_ctrl.sv
// In-order branch-resolution controller feeding the sptag generator.
// Optional macro SPTAG_CTRL_BYPASS_EN: a resolution hitting the current head
// retires in its arrival cycle (pulse one cycle earlier).
module sptag_ctrl
    import sptag_ctrl_pkg::*;
#(
    parameter int SPTAG_WIDTH = SPTAG_WIDTH_DEF,
    parameter int PC_WIDTH    = RV32_PC_WIDTH
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           i_dispatch_en,
    input  logic                           i_is_br_1,
    input  logic                           i_is_br_2,
    input  logic [SPTAG_WIDTH-1:0]         i_inst_sptag_1,
    input  logic [SPTAG_WIDTH-1:0]         i_inst_sptag_2,
    input  logic                           i_res_valid,
    input  logic [SPTAG_WIDTH-1:0]         i_res_sptag,
    input  logic                           i_res_miss,
    input  logic [PC_WIDTH-1:0]            i_res_target,
    output logic                           o_prsuc,
    output logic                           o_prmiss,
    output logic [PC_WIDTH-1:0]            o_prmiss_pc,
    output logic [SPTAG_WIDTH-1:0]         o_sptag_fix,
    output logic [$clog2(SPTAG_WIDTH)-1:0] o_inflight
);

    localparam int CNT_W = (SPTAG_WIDTH == SPTAG_WIDTH_DEF) ? SPDEPTH_WIDTH : $clog2(SPTAG_WIDTH);

    ret_state_e             state_q, state_d;
    logic                   prsuc_q, prsuc_d;
    logic                   prmiss_q, prmiss_d;
    logic [PC_WIDTH-1:0]    pc_q, pc_d;
    logic [SPTAG_WIDTH-1:0] fix_q, fix_d;

    logic                   flush_cycle;
    logic                   push1, push2, res_en;
    logic                   bypass_hit;
    logic                   ret_en, ret_miss;
    logic [PC_WIDTH-1:0]    ret_target;
    logic                   q_pop, q_flush;
    logic [SPTAG_WIDTH-1:0] q_head_tag;
    logic                   q_head_done, q_head_miss;
    logic [PC_WIDTH-1:0]    q_head_target;
    logic [CNT_W-1:0]       q_count;

    // Tag that was current before the branch: generator advances by rotating left.
    function automatic logic [SPTAG_WIDTH-1:0] rot_back(input logic [SPTAG_WIDTH-1:0] tag);
        return {tag[0], tag[SPTAG_WIDTH-1:1]};
    endfunction

    // Retire decision on the head entry plus gating of pushes/resolutions.
    always_comb begin
        // The generator drops its allocation while a redirect is visible; mirror that.
        flush_cycle = (state_q == RET_MISS);
        push1       = i_dispatch_en && i_is_br_1 && !flush_cycle;
        push2       = i_dispatch_en && i_is_br_2 && !flush_cycle;
        res_en      = i_res_valid && !flush_cycle;

        bypass_hit = 1'b0;
`ifdef SPTAG_CTRL_BYPASS_EN
        bypass_hit = res_en && (q_count != '0) && !q_head_done && (i_res_sptag == q_head_tag);
`endif

        ret_en     = q_head_done || bypass_hit;
        ret_miss   = q_head_done ? q_head_miss   : i_res_miss;
        ret_target = q_head_done ? q_head_target : i_res_target;

        state_d  = RET_IDLE;
        prsuc_d  = 1'b0;
        prmiss_d = 1'b0;
        pc_d     = pc_q;
        fix_d    = fix_q;
        if (ret_en) begin
            if (ret_miss) begin
                state_d  = RET_MISS;
                prmiss_d = 1'b1;
                pc_d     = ret_target;
                fix_d    = rot_back(q_head_tag);
            end else begin
                state_d = RET_SUC;
                prsuc_d = 1'b1;
            end
        end

        q_pop   = ret_en && !ret_miss;
        q_flush = ret_en && ret_miss;
    end

    // Registered retire FSM and its output pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= RET_IDLE;
            prsuc_q  <= 1'b0;
            prmiss_q <= 1'b0;
            pc_q     <= '0;
            fix_q    <= {{(SPTAG_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            state_q  <= state_d;
            prsuc_q  <= prsuc_d;
            prmiss_q <= prmiss_d;
            pc_q     <= pc_d;
            fix_q    <= fix_d;
        end
    end

    sptag_order_q #(
        .SPTAG_WIDTH (SPTAG_WIDTH),
        .PC_WIDTH    (PC_WIDTH),
        .CNT_W       (CNT_W)
    ) u_order_q (
        .clk         (clk),
        .rst         (rst),
        .push1       (push1),
        .push1_tag   (i_inst_sptag_1),
        .push2       (push2),
        .push2_tag   (i_inst_sptag_2),
        .pop         (q_pop),
        .flush       (q_flush),
        .res_en      (res_en),
        .res_tag     (i_res_sptag),
        .res_miss    (i_res_miss),
        .res_target  (i_res_target),
        .head_tag    (q_head_tag),
        .head_done   (q_head_done),
        .head_miss   (q_head_miss),
        .head_target (q_head_target),
        .count       (q_count)
    );

    assign o_prsuc     = prsuc_q;
    assign o_prmiss    = prmiss_q;
    assign o_prmiss_pc = pc_q;
    assign o_sptag_fix = fix_q;
    assign o_inflight  = q_count;

endmodule

// File: tb/tb_sptag_ctrl.sv
// Directed bench for sptag_ctrl (default width 5, PC width 32).
module tb_sptag_ctrl;

    logic        clk;
    logic        rst;
    logic        i_dispatch_en;
    logic        i_is_br_1;
    logic        i_is_br_2;
    logic [4:0]  i_inst_sptag_1;
    logic [4:0]  i_inst_sptag_2;
    logic        i_res_valid;
    logic [4:0]  i_res_sptag;
    logic        i_res_miss;
    logic [31:0] i_res_target;
    logic        o_prsuc;
    logic        o_prmiss;
    logic [31:0] o_prmiss_pc;
    logic [4:0]  o_sptag_fix;
    logic [2:0]  o_inflight;

    int n_assert = 0;
    int n_fail   = 0;

    sptag_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .i_dispatch_en  (i_dispatch_en),
        .i_is_br_1      (i_is_br_1),
        .i_is_br_2      (i_is_br_2),
        .i_inst_sptag_1 (i_inst_sptag_1),
        .i_inst_sptag_2 (i_inst_sptag_2),
        .i_res_valid    (i_res_valid),
        .i_res_sptag    (i_res_sptag),
        .i_res_miss     (i_res_miss),
        .i_res_target   (i_res_target),
        .o_prsuc        (o_prsuc),
        .o_prmiss       (o_prmiss),
        .o_prmiss_pc    (o_prmiss_pc),
        .o_sptag_fix    (o_sptag_fix),
        .o_inflight     (o_inflight)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        i_dispatch_en  = 1'b0;
        i_is_br_1      = 1'b0;
        i_is_br_2      = 1'b0;
        i_inst_sptag_1 = '0;
        i_inst_sptag_2 = '0;
        i_res_valid    = 1'b0;
        i_res_sptag    = '0;
        i_res_miss     = 1'b0;
        i_res_target   = '0;
    endtask

    task automatic dispatch(input logic b1, input logic [4:0] t1, input logic b2, input logic [4:0] t2);
        i_dispatch_en  = 1'b1;
        i_is_br_1      = b1;
        i_inst_sptag_1 = t1;
        i_is_br_2      = b2;
        i_inst_sptag_2 = t2;
    endtask

    task automatic resolve(input logic [4:0] t, input logic miss, input logic [31:0] tgt);
        i_res_valid  = 1'b1;
        i_res_sptag  = t;
        i_res_miss   = miss;
        i_res_target = tgt;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        tick();
        tick();
        chk("rst_prsuc",    o_prsuc,     1'b0);
        chk("rst_prmiss",   o_prmiss,    1'b0);
        chk("rst_pc",       o_prmiss_pc, 32'h0);
        chk("rst_fix",      o_sptag_fix, 5'b00001);
        chk("rst_inflight", o_inflight,  3'd0);
        rst = 1'b0;

        // Single branch, resolved hit
        dispatch(1'b1, 5'b00010, 1'b0, 5'b00000);
        tick();
        idle();
        chk("t1_inflight_push", o_inflight, 3'd1);
        chk("t1_prsuc_push",    o_prsuc,    1'b0);
        resolve(5'b00010, 1'b0, 32'h0);
        tick();
        idle();
`ifdef SPTAG_CTRL_BYPASS_EN
        chk("t1_prsuc_t1",    o_prsuc,    1'b1);
        chk("t1_inflight_t1", o_inflight, 3'd0);
        tick();
        chk("t1_prsuc_t2",    o_prsuc,    1'b0);
`else
        chk("t1_prsuc_t1",    o_prsuc,    1'b0);
        chk("t1_inflight_t1", o_inflight, 3'd1);
        tick();
        chk("t1_prsuc_t2",    o_prsuc,    1'b1);
        chk("t1_inflight_t2", o_inflight, 3'd0);
        tick();
        chk("t1_prsuc_t3",    o_prsuc,    1'b0);
`endif

`ifndef SPTAG_CTRL_BYPASS_EN
        // Dual push, younger resolves first
        dispatch(1'b1, 5'b00010, 1'b1, 5'b00100);
        tick();
        idle();
        chk("t2_inflight_push", o_inflight, 3'd2);
        resolve(5'b00100, 1'b0, 32'h0);
        tick();
        idle();
        chk("t2_prsuc_a", o_prsuc, 1'b0);
        resolve(5'b00010, 1'b0, 32'h0);
        tick();
        idle();
        chk("t2_prsuc_b", o_prsuc, 1'b0);
        tick();
        chk("t2_prsuc_old",    o_prsuc,    1'b1);
        chk("t2_inflight_old", o_inflight, 3'd1);
        tick();
        chk("t2_prsuc_young",    o_prsuc,    1'b1);
        chk("t2_inflight_young", o_inflight, 3'd0);
        tick();
        chk("t2_prsuc_end", o_prsuc, 1'b0);

        // Fill the queue, head mispredicts
        dispatch(1'b1, 5'b00010, 1'b1, 5'b00100);
        tick();
        dispatch(1'b1, 5'b01000, 1'b1, 5'b10000);
        tick();
        idle();
        chk("t4_inflight_full", o_inflight, 3'd4);
        resolve(5'b00010, 1'b1, 32'h80);
        tick();
        idle();
        chk("t4_prmiss_wait", o_prmiss, 1'b0);
        tick();
        chk("t4_prmiss",   o_prmiss,    1'b1);
        chk("t4_pc",       o_prmiss_pc, 32'h80);
        chk("t4_fix",      o_sptag_fix, 5'b00001);
        chk("t4_inflight", o_inflight,  3'd0);
        chk("t4_prsuc",    o_prsuc,     1'b0);
        dispatch(1'b1, 5'b00010, 1'b0, 5'b00000);
        tick();
        idle();
        chk("t4_push_dropped", o_inflight, 3'd0);
        chk("t4_prmiss_end",   o_prmiss,   1'b0);

        // Younger mispredicts, older hits
        dispatch(1'b1, 5'b00010, 1'b1, 5'b00100);
        tick();
        idle();
        resolve(5'b00100, 1'b1, 32'h1234);
        tick();
        resolve(5'b00010, 1'b0, 32'h0);
        tick();
        idle();
        chk("t3_quiet", o_prsuc | o_prmiss, 1'b0);
        tick();
        chk("t3_prsuc",  o_prsuc,  1'b1);
        chk("t3_prmiss0", o_prmiss, 1'b0);
        tick();
        chk("t3_prmiss",   o_prmiss,    1'b1);
        chk("t3_prsuc0",   o_prsuc,     1'b0);
        chk("t3_pc",       o_prmiss_pc, 32'h1234);
        chk("t3_fix",      o_sptag_fix, 5'b00010);
        chk("t3_inflight", o_inflight,  3'd0);
        tick();
        chk("t3_prmiss_end", o_prmiss,    1'b0);
        chk("t3_fix_hold",   o_sptag_fix, 5'b00010);

        // Unknown tag resolution is ignored
        dispatch(1'b1, 5'b00010, 1'b0, 5'b00000);
        tick();
        idle();
        resolve(5'b10000, 1'b0, 32'h0);
        tick();
        idle();
        tick();
        tick();
        chk("t5_prsuc",    o_prsuc,    1'b0);
        chk("t5_prmiss",   o_prmiss,   1'b0);
        chk("t5_inflight", o_inflight, 3'd1);
        resolve(5'b00010, 1'b0, 32'h0);
        tick();
        idle();
        tick();
        chk("t5_drain_prsuc",    o_prsuc,    1'b1);
        chk("t5_drain_inflight", o_inflight, 3'd0);
        tick();
`endif

        // Reset with three pending branches
        dispatch(1'b1, 5'b00010, 1'b1, 5'b00100);
        tick();
        dispatch(1'b1, 5'b01000, 1'b0, 5'b00000);
        tick();
        idle();
        chk("t6_inflight_pend", o_inflight, 3'd3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_inflight_rst", o_inflight,  3'd0);
        chk("t6_fix_rst",      o_sptag_fix, 5'b00001);
        chk("t6_prsuc_rst",    o_prsuc,     1'b0);
        resolve(5'b00010, 1'b0, 32'h0);
        tick();
        idle();
        chk("t6_prsuc_a", o_prsuc, 1'b0);
        tick();
        chk("t6_prsuc_b",   o_prsuc,     1'b0);
        chk("t6_prmiss_b",  o_prmiss,    1'b0);
        chk("t6_inflight",  o_inflight,  3'd0);
        chk("t6_fix",       o_sptag_fix, 5'b00001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
